reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Receiving end of the issue-to-RS dispatch interface. Accepts one decoded ALU, branch, JAL, JALR, AUIPC or LUI-class op per cycle from the issue stage.
- Holds each op until both operands are known, capturing results broadcast on two common data buses (ALU and LSB).
- Sends one ready op per cycle to the single-cycle ALU. Sits between issue and ALU, alongside the ROB and load/store buffer.

Parameters:
DEPTH, 8, number of entries (power of two, 2..16)
IDX_W, 3, log2(DEPTH)

Ports:
clk_in  input  1  system clock, single clock domain
rst_in  input  1  asynchronous, active-low reset (0 = reset)
rdy_in  input  1  global ready; low freezes all state and outputs
_clear  input  1  flush (mispredict); synchronous
_rs_ready  input  1  issue writes one entry this cycle
_rs_type  input  7  opcode
_rs_op  input  4  ALU/branch sub-op
_rs_rob_id  input  5  destination ROB tag
_rs_r1  input  32  operand 1 value (valid when no dep)
_rs_r2  input  32  operand 2 value (valid when no dep)
_rs_imm  input  32  immediate
_rs_has_dep1  input  1  operand 1 waits on _rs_dep1
_rs_dep1  input  5  producer tag, operand 1
_rs_has_dep2  input  1  operand 2 waits on _rs_dep2
_rs_dep2  input  5  producer tag, operand 2
_rs_full  output  1  no free entry
_cdb_alu_valid  input  1  ALU result broadcast
_cdb_alu_rob_id  input  5  tag of ALU result
_cdb_alu_value  input  32  ALU result
_cdb_lsb_valid  input  1  load result broadcast
_cdb_lsb_rob_id  input  5  tag of load result
_cdb_lsb_value  input  32  load result
_alu_valid  output  1  op presented to ALU this cycle
_alu_type  output  7  opcode
_alu_op  output  4  sub-op
_alu_rob_id  output  5  ROB tag
_alu_r1  output  32  operand 1
_alu_r2  output  32  operand 2
_alu_imm  output  32  immediate

Behaviour:
- Entry fields: busy, type, op, rob_id, v1, v2, h1, h2, q1, q2, imm.
- Reset (rst_in=0, async): all busy=0; every output 0. _rs_full resets to 0 because it is derived from busy.
- rdy_in=0: no register changes at all; outputs hold.
- _rs_full:
  - Combinational, =1 iff all DEPTH entries are busy, from registered state only.
  - Not relieved by a same-cycle dispatch.
  - Issue must not assert _rs_ready while full; if it does, the write is dropped.
- Allocation (_rs_ready=1, not full): write into lowest-index free entry at the clock edge.
- Issue-time bypass: if h1 and _rs_dep1 matches a valid CDB tag this cycle, store v1 = that CDB value and h1=0. Same for operand 2.
  - The ALU CDB wins if both buses carry the same tag; this is illegal but deterministic.
- Wakeup: every busy entry with hN=1 and qN equal to a valid CDB tag captures the value and clears hN at the edge. Both CDBs are processed in the same cycle.
- Ready: busy && !h1 && !h2, evaluated on registered state. An entry woken at edge N is first selectable in the cycle after edge N.
- Dispatch:
  - Each cycle, select the lowest-index ready entry.
  - At the edge: _alu_* <= entry fields, _alu_valid <= 1, entry busy <= 0.
  - If no entry is ready: _alu_valid <= 0; other _alu_* fields hold.
  - Latency from ready to _alu_valid high is 1 cycle.
  - The ALU accepts every cycle; there is no backpressure.
- Simultaneous allocate + dispatch + wakeup in one cycle is legal.
  - The freed slot is not reused in the same cycle; allocation picks from slots free before the edge.
- _clear=1 (rdy_in=1):
  - All busy <= 0 and _alu_valid <= 0.
  - Allocation, wakeup and dispatch in that cycle are discarded.
  - _clear has priority over everything except reset.
- Tag 0 is never a valid producer tag. Deps are governed by the has_dep flags, not by tag value.

Test Plan:
- Ready-on-issue: issue ADD (op 0, r1=5, r2=7, no deps, tag 3) into an empty RS → next cycle _alu_valid=1, rob_id=3, r1=5, r2=7; following cycle _alu_valid=0.
- Wakeup from each CDB: issue with h1=1,q1=4 and h2=1,q2=6. Drive ALU CDB tag 4=0x10, then LSB CDB tag 6=0x20 two cycles later → dispatch 1 cycle after the second broadcast with r1=0x10, r2=0x20.
- Bypass: issue with h1=1,q1=9 while _cdb_alu_valid=1 tag 9 value 0xAB → dispatch next cycle with r1=0xAB.
- Full / ordering: fill 8 entries all waiting on tag 2 → _rs_full=1. Broadcast tag 2 → entries dispatch in index order 0..7 on consecutive cycles; _rs_full drops the cycle after the first dispatch.
- Flush: 5 busy entries plus _clear together with _rs_ready and a CDB hit → next cycle _rs_full=0, _alu_valid=0, and no later dispatch.
- Freeze / reset: hold rdy_in=0 for 3 cycles with a ready entry → no dispatch until rdy_in=1. Assert rst_in=0 mid-dispatch → _alu_valid=0 immediately, asynchronously.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station
//
// Holds decoded ALU/branch/JAL/JALR/AUIPC/LUI ops from issue until both
// operands are known, snooping the ALU and LSB common data buses for results,
// and sends the lowest-index ready op to the single-cycle ALU each cycle.
//
// Ports
//   clk_in, rst_in (async, active low), rdy_in (low = freeze everything)
//   _clear                       synchronous flush, beats everything but reset
//   _rs_*                        issue-side write of one entry, _rs_full back
//   _cdb_alu_*, _cdb_lsb_*       result broadcasts (tag + value)
//   _alu_*                       registered op presented to the ALU
module reservation_station #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,

    input  logic        _rs_ready,
    input  logic [6:0]  _rs_type,
    input  logic [3:0]  _rs_op,
    input  logic [4:0]  _rs_rob_id,
    input  logic [31:0] _rs_r1,
    input  logic [31:0] _rs_r2,
    input  logic [31:0] _rs_imm,
    input  logic        _rs_has_dep1,
    input  logic [4:0]  _rs_dep1,
    input  logic        _rs_has_dep2,
    input  logic [4:0]  _rs_dep2,
    output logic        _rs_full,

    input  logic        _cdb_alu_valid,
    input  logic [4:0]  _cdb_alu_rob_id,
    input  logic [31:0] _cdb_alu_value,
    input  logic        _cdb_lsb_valid,
    input  logic [4:0]  _cdb_lsb_rob_id,
    input  logic [31:0] _cdb_lsb_value,

    output logic        _alu_valid,
    output logic [6:0]  _alu_type,
    output logic [3:0]  _alu_op,
    output logic [4:0]  _alu_rob_id,
    output logic [31:0] _alu_r1,
    output logic [31:0] _alu_r2,
    output logic [31:0] _alu_imm
);

    // Entry storage
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] h1_q;
    logic [DEPTH-1:0] h2_q;
    logic [6:0]       type_q [DEPTH];
    logic [3:0]       op_q   [DEPTH];
    logic [4:0]       rob_q  [DEPTH];
    logic [31:0]      v1_q   [DEPTH];
    logic [31:0]      v2_q   [DEPTH];
    logic [4:0]       q1_q   [DEPTH];
    logic [4:0]       q2_q   [DEPTH];
    logic [31:0]      imm_q  [DEPTH];

    logic [DEPTH-1:0] ready_vec;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             disp_found;
    logic [IDX_W-1:0] disp_idx;

    logic             in_h1;
    logic             in_h2;
    logic [31:0]      in_v1;
    logic [31:0]      in_v2;

    // Full is purely from registered busy bits; a same-cycle dispatch does not relieve it.
    assign _rs_full  = &busy_q;
    assign ready_vec = busy_q & ~h1_q & ~h2_q;

    // Lowest-index free slot and lowest-index ready slot, both from pre-edge state,
    // so a slot freed by dispatch is never reallocated in the same cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready_vec[i] && !disp_found) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end
    end

    // Issue-time bypass; the ALU bus wins a (never legal) tag tie.
    always_comb begin
        in_h1 = _rs_has_dep1;
        in_v1 = _rs_r1;
        if (_rs_has_dep1) begin
            if (_cdb_alu_valid && (_cdb_alu_rob_id == _rs_dep1)) begin
                in_h1 = 1'b0;
                in_v1 = _cdb_alu_value;
            end else if (_cdb_lsb_valid && (_cdb_lsb_rob_id == _rs_dep1)) begin
                in_h1 = 1'b0;
                in_v1 = _cdb_lsb_value;
            end
        end
        in_h2 = _rs_has_dep2;
        in_v2 = _rs_r2;
        if (_rs_has_dep2) begin
            if (_cdb_alu_valid && (_cdb_alu_rob_id == _rs_dep2)) begin
                in_h2 = 1'b0;
                in_v2 = _cdb_alu_value;
            end else if (_cdb_lsb_valid && (_cdb_lsb_rob_id == _rs_dep2)) begin
                in_h2 = 1'b0;
                in_v2 = _cdb_lsb_value;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q      <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                type_q[i] <= '0;
                op_q[i]   <= '0;
                rob_q[i]  <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
                q1_q[i]   <= '0;
                q2_q[i]   <= '0;
                imm_q[i]  <= '0;
            end
            _alu_valid  <= 1'b0;
            _alu_type   <= '0;
            _alu_op     <= '0;
            _alu_rob_id <= '0;
            _alu_r1     <= '0;
            _alu_r2     <= '0;
            _alu_imm    <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                busy_q     <= '0;
                _alu_valid <= 1'b0;
            end else begin
                // Wakeup: both buses are snooped by every waiting entry.
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (busy_q[i] && h1_q[i]) begin
                        if (_cdb_alu_valid && (_cdb_alu_rob_id == q1_q[i])) begin
                            h1_q[i] <= 1'b0;
                            v1_q[i] <= _cdb_alu_value;
                        end else if (_cdb_lsb_valid && (_cdb_lsb_rob_id == q1_q[i])) begin
                            h1_q[i] <= 1'b0;
                            v1_q[i] <= _cdb_lsb_value;
                        end
                    end
                    if (busy_q[i] && h2_q[i]) begin
                        if (_cdb_alu_valid && (_cdb_alu_rob_id == q2_q[i])) begin
                            h2_q[i] <= 1'b0;
                            v2_q[i] <= _cdb_alu_value;
                        end else if (_cdb_lsb_valid && (_cdb_lsb_rob_id == q2_q[i])) begin
                            h2_q[i] <= 1'b0;
                            v2_q[i] <= _cdb_lsb_value;
                        end
                    end
                end

                // Allocation targets a slot that was free before the edge, so it
                // never collides with the wakeup or dispatch writes above/below.
                if (_rs_ready && free_found) begin
                    busy_q[free_idx] <= 1'b1;
                    type_q[free_idx] <= _rs_type;
                    op_q[free_idx]   <= _rs_op;
                    rob_q[free_idx]  <= _rs_rob_id;
                    imm_q[free_idx]  <= _rs_imm;
                    q1_q[free_idx]   <= _rs_dep1;
                    q2_q[free_idx]   <= _rs_dep2;
                    h1_q[free_idx]   <= in_h1;
                    h2_q[free_idx]   <= in_h2;
                    v1_q[free_idx]   <= in_v1;
                    v2_q[free_idx]   <= in_v2;
                end

                if (disp_found) begin
                    busy_q[disp_idx] <= 1'b0;
                    _alu_valid       <= 1'b1;
                    _alu_type        <= type_q[disp_idx];
                    _alu_op          <= op_q[disp_idx];
                    _alu_rob_id      <= rob_q[disp_idx];
                    _alu_r1          <= v1_q[disp_idx];
                    _alu_r2          <= v2_q[disp_idx];
                    _alu_imm         <= imm_q[disp_idx];
                end else begin
                    _alu_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a behavioural entry-pool model checked
// on every falling edge, plus hand-computed expectations for each scenario.
module tb_reservation_station;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        rs_ready;
    logic [6:0]  rs_type;
    logic [3:0]  rs_op;
    logic [4:0]  rs_rob;
    logic [31:0] rs_r1;
    logic [31:0] rs_r2;
    logic [31:0] rs_imm;
    logic        rs_hd1;
    logic [4:0]  rs_dep1;
    logic        rs_hd2;
    logic [4:0]  rs_dep2;
    logic        rs_full;
    logic        ca_valid;
    logic [4:0]  ca_tag;
    logic [31:0] ca_val;
    logic        cl_valid;
    logic [4:0]  cl_tag;
    logic [31:0] cl_val;
    logic        alu_valid;
    logic [6:0]  alu_type;
    logic [3:0]  alu_op;
    logic [4:0]  alu_rob;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [31:0] alu_imm;

    reservation_station #(.DEPTH(8), .IDX_W(3)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (clear),
        ._rs_ready      (rs_ready),
        ._rs_type       (rs_type),
        ._rs_op         (rs_op),
        ._rs_rob_id     (rs_rob),
        ._rs_r1         (rs_r1),
        ._rs_r2         (rs_r2),
        ._rs_imm        (rs_imm),
        ._rs_has_dep1   (rs_hd1),
        ._rs_dep1       (rs_dep1),
        ._rs_has_dep2   (rs_hd2),
        ._rs_dep2       (rs_dep2),
        ._rs_full       (rs_full),
        ._cdb_alu_valid (ca_valid),
        ._cdb_alu_rob_id(ca_tag),
        ._cdb_alu_value (ca_val),
        ._cdb_lsb_valid (cl_valid),
        ._cdb_lsb_rob_id(cl_tag),
        ._cdb_lsb_value (cl_val),
        ._alu_valid     (alu_valid),
        ._alu_type      (alu_type),
        ._alu_op        (alu_op),
        ._alu_rob_id    (alu_rob),
        ._alu_r1        (alu_r1),
        ._alu_r2        (alu_r2),
        ._alu_imm       (alu_imm)
    );

    initial forever #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        logic [6:0]  typ;
        logic [3:0]  op;
        logic [4:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        bit          w1;   // still waiting on operand 1
        bit          w2;
        logic [4:0]  t1;
        logic [4:0]  t2;
    } ent_t;

    ent_t        pool [DEPTH];
    bit          e_valid;
    logic [6:0]  e_type;
    logic [3:0]  e_op;
    logic [4:0]  e_rob;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_imm;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pool[i].busy = 0; pool[i].typ = '0; pool[i].op = '0; pool[i].rob = '0;
            pool[i].v1 = '0; pool[i].v2 = '0; pool[i].imm = '0;
            pool[i].w1 = 0; pool[i].w2 = 0; pool[i].t1 = '0; pool[i].t2 = '0;
        end
        e_valid = 0; e_type = '0; e_op = '0; e_rob = '0; e_r1 = '0; e_r2 = '0; e_imm = '0;
    endtask

    // Does any bus broadcast this tag now? ALU bus takes precedence.
    function automatic bit bus_hit(input logic [4:0] tag, output logic [31:0] val);
        val = '0;
        if (ca_valid && ca_tag == tag) begin val = ca_val; return 1; end
        if (cl_valid && cl_tag == tag) begin val = cl_val; return 1; end
        return 0;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < DEPTH; i++) if (!pool[i].busy) return 0;
        return 1;
    endfunction

    task automatic model_step();
        int d;
        int f;
        logic [31:0] v;
        d = -1;
        f = -1;
        if (!rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) pool[i].busy = 0;
                e_valid = 0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (d < 0 && pool[i].busy && !pool[i].w1 && !pool[i].w2) d = i;
                    if (f < 0 && !pool[i].busy) f = i;
                end
                if (d >= 0) begin
                    e_valid = 1; e_type = pool[d].typ; e_op = pool[d].op; e_rob = pool[d].rob;
                    e_r1 = pool[d].v1; e_r2 = pool[d].v2; e_imm = pool[d].imm;
                end else begin
                    e_valid = 0;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (pool[i].busy && pool[i].w1 && bus_hit(pool[i].t1, v)) begin
                        pool[i].w1 = 0; pool[i].v1 = v;
                    end
                    if (pool[i].busy && pool[i].w2 && bus_hit(pool[i].t2, v)) begin
                        pool[i].w2 = 0; pool[i].v2 = v;
                    end
                end
                if (rs_ready && f >= 0) begin
                    pool[f].busy = 1; pool[f].typ = rs_type; pool[f].op = rs_op;
                    pool[f].rob = rs_rob; pool[f].imm = rs_imm;
                    pool[f].t1 = rs_dep1; pool[f].t2 = rs_dep2;
                    pool[f].v1 = rs_r1; pool[f].w1 = rs_hd1;
                    pool[f].v2 = rs_r2; pool[f].w2 = rs_hd2;
                    if (rs_hd1 && bus_hit(rs_dep1, v)) begin pool[f].w1 = 0; pool[f].v1 = v; end
                    if (rs_hd2 && bus_hit(rs_dep2, v)) begin pool[f].w2 = 0; pool[f].v2 = v; end
                end
                if (d >= 0) pool[d].busy = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            model_step();
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) model_reset();
            chk("m_full", 32'(rs_full), 32'(model_full()));
            chk("m_valid", 32'(alu_valid), 32'(e_valid));
            chk("m_type", 32'(alu_type), 32'(e_type));
            chk("m_op", 32'(alu_op), 32'(e_op));
            chk("m_rob", 32'(alu_rob), 32'(e_rob));
            chk("m_r1", alu_r1, e_r1);
            chk("m_r2", alu_r2, e_r2);
            chk("m_imm", alu_imm, e_imm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk_in);
        rs_ready = 0;
        ca_valid = 0;
        cl_valid = 0;
        clear    = 0;
    endtask

    task automatic issue(input logic [6:0] typ, input logic [3:0] op, input logic [4:0] rob,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic hd1, input logic [4:0] d1,
                         input logic hd2, input logic [4:0] d2);
        rs_ready = 1; rs_type = typ; rs_op = op; rs_rob = rob;
        rs_r1 = r1; rs_r2 = r2; rs_imm = imm;
        rs_hd1 = hd1; rs_dep1 = d1; rs_hd2 = hd2; rs_dep2 = d2;
    endtask

    task automatic cdb_alu(input logic [4:0] tag, input logic [31:0] val);
        ca_valid = 1; ca_tag = tag; ca_val = val;
    endtask

    task automatic cdb_lsb(input logic [4:0] tag, input logic [31:0] val);
        cl_valid = 1; cl_tag = tag; cl_val = val;
    endtask

    initial begin
        rdy_in = 1; clear = 0; rs_ready = 0; rs_type = '0; rs_op = '0; rs_rob = '0;
        rs_r1 = '0; rs_r2 = '0; rs_imm = '0; rs_hd1 = 0; rs_dep1 = '0; rs_hd2 = 0;
        rs_dep2 = '0; ca_valid = 0; ca_tag = '0; ca_val = '0; cl_valid = 0; cl_tag = '0;
        cl_val = '0;
        rst_in = 1;
        #1 rst_in = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_valid", 32'(alu_valid), 0);
        chk("rst_full", 32'(rs_full), 0);
        chk("rst_rob", 32'(alu_rob), 0);
        rst_in = 1;
        step();

        // Ready on issue
        issue(7'h33, 4'd0, 5'd3, 32'd5, 32'd7, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        chk("t1_wait", 32'(alu_valid), 0);
        step();
        chk("t1_valid", 32'(alu_valid), 1);
        chk("t1_rob", 32'(alu_rob), 3);
        chk("t1_r1", alu_r1, 5);
        chk("t1_r2", alu_r2, 7);
        step();
        chk("t1_idle", 32'(alu_valid), 0);

        // Wakeup from each bus
        issue(7'h63, 4'd1, 5'd5, 32'hdead, 32'hbeef, 32'h8, 1, 5'd4, 1, 5'd6);
        step();
        cdb_alu(5'd4, 32'h10);
        step();
        step();
        cdb_lsb(5'd6, 32'h20);
        step();
        chk("t2_notyet", 32'(alu_valid), 0);
        step();
        chk("t2_valid", 32'(alu_valid), 1);
        chk("t2_rob", 32'(alu_rob), 5);
        chk("t2_r1", alu_r1, 32'h10);
        chk("t2_r2", alu_r2, 32'h20);
        step();

        // Issue-time bypass
        issue(7'h13, 4'd0, 5'd8, 32'd0, 32'd3, 32'd4, 1, 5'd9, 0, 5'd0);
        cdb_alu(5'd9, 32'hAB);
        step();
        step();
        chk("t3_valid", 32'(alu_valid), 1);
        chk("t3_r1", alu_r1, 32'hAB);
        chk("t3_imm", alu_imm, 32'h4);
        step();
        issue(7'h33, 4'd2, 5'd9, 32'd0, 32'd0, 32'd0, 1, 5'd12, 1, 5'd13);
        cdb_alu(5'd13, 32'h55);
        cdb_lsb(5'd12, 32'h66);
        step();
        step();
        chk("t3b_r1", alu_r1, 32'h66);
        chk("t3b_r2", alu_r2, 32'h55);
        step();
        issue(7'h33, 4'd3, 5'd10, 32'd1, 32'd0, 32'd0, 0, 5'd0, 1, 5'd11);
        cdb_alu(5'd11, 32'h111);
        cdb_lsb(5'd11, 32'h222);
        step();
        step();
        chk("t3c_tie", alu_r2, 32'h111);
        step();

        // Fill, drop while full, in-order drain
        for (int i = 0; i < 8; i++) begin
            issue(7'h33, 4'd0, 5'(16 + i), 32'(i), 32'd0, 32'd0, 1, 5'd2, 0, 5'd0);
            step();
        end
        chk("t4_full", 32'(rs_full), 1);
        issue(7'h37, 4'd0, 5'd31, 32'd1, 32'd1, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        chk("t4_full2", 32'(rs_full), 1);
        cdb_alu(5'd2, 32'h77);
        step();
        chk("t4_full3", 32'(rs_full), 1);
        chk("t4_notyet", 32'(alu_valid), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4_valid", 32'(alu_valid), 1);
            chk("t4_order", 32'(alu_rob), 32'(16 + i));
            chk("t4_r1", alu_r1, 32'h77);
            if (i == 0) chk("t4_fulldrop", 32'(rs_full), 0);
        end
        step();
        chk("t4_dropped", 32'(alu_valid), 0);

        // Flush beats allocate, wakeup and dispatch
        for (int i = 0; i < 4; i++) begin
            issue(7'h33, 4'd0, 5'(1 + i), 32'd0, 32'd0, 32'd0, 1, 5'd30, 0, 5'd0);
            step();
        end
        issue(7'h33, 4'd0, 5'd5, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        clear = 1;
        issue(7'h33, 4'd0, 5'd6, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0);
        cdb_alu(5'd30, 32'h99);
        step();
        chk("t5_full", 32'(rs_full), 0);
        chk("t5_valid", 32'(alu_valid), 0);
        repeat (3) begin
            step();
            chk("t5_none", 32'(alu_valid), 0);
        end

        // Allocate + dispatch + wakeup in one cycle
        issue(7'h33, 4'd0, 5'd20, 32'd0, 32'd1, 32'd0, 1, 5'd25, 0, 5'd0);
        step();
        issue(7'h33, 4'd0, 5'd21, 32'd2, 32'd2, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        issue(7'h33, 4'd0, 5'd22, 32'd3, 32'd3, 32'd0, 0, 5'd0, 0, 5'd0);
        cdb_alu(5'd25, 32'h7);
        step();
        chk("t6_first", 32'(alu_rob), 21);
        step();
        chk("t6_second", 32'(alu_rob), 20);
        chk("t6_woken", alu_r1, 32'h7);
        step();
        chk("t6_third", 32'(alu_rob), 22);
        step();
        chk("t6_idle", 32'(alu_valid), 0);

        // Freeze
        issue(7'h33, 4'd0, 5'd12, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        rdy_in = 0;
        repeat (3) begin
            step();
            chk("t7_frozen", 32'(alu_valid), 0);
        end
        rdy_in = 1;
        step();
        chk("t7_go", 32'(alu_valid), 1);
        chk("t7_rob", 32'(alu_rob), 12);
        rdy_in = 0;
        issue(7'h33, 4'd0, 5'd13, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        chk("t7_hold", 32'(alu_valid), 1);
        step();
        chk("t7_hold_rob", 32'(alu_rob), 12);
        rdy_in = 1;
        step();
        chk("t7_after", 32'(alu_valid), 0);
        step();
        chk("t7_nodrop", 32'(alu_valid), 0);

        // Async reset mid-dispatch
        issue(7'h33, 4'd0, 5'd14, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0);
        step();
        step();
        chk("t8_pre", 32'(alu_valid), 1);
        #2 rst_in = 0;
        #1;
        chk("t8_async", 32'(alu_valid), 0);
        chk("t8_rob", 32'(alu_rob), 0);
        step();
        rst_in = 1;
        step();
        chk("t8_after", 32'(alu_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
